zv_compressor128: RTL and testbench
===================================

ZV_COMPRESSOR128 -- requirements
Module: zv_compressor128

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, bit width of one line word.
REQ-002 SHALL have parameter DIST_WIDTH, default 7, bit width of one distance field.
REQ-003 SHALL have parameter MAX_LIFM_RSIZ, default 4, number of distance fields per word's map entry.
REQ-004 SHALL fix the line size at 128 words; it is not a parameter.
REQ-005 SHALL define the entry width ME as DIST_WIDTH*MAX_LIFM_RSIZ, which is 28 bits at the defaults.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: a synchronous, active-high reset, asserted when 1; the name is kept to match the codebase.
REQ-008 SHALL have port lifm_line, input, 128*WORD_WIDTH bits: the input line, with word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-009 SHALL have port mt_line, input, 128*ME bits: the map entries, with entry i at bits [i*ME +: ME], paired with word i.
REQ-010 SHALL have port lifm_comp, output, 128*WORD_WIDTH bits: the compressed line, in the same slot layout as lifm_line.
REQ-011 SHALL have port mt_comp, output, 128*ME bits: the compressed map entries, in the same slot layout as mt_line.

Function
REQ-012 SHALL classify word i as nonzero when any bit of it is 1; an all-zero word is a zero word.
REQ-013 SHALL drop every zero word together with its paired mt entry.
REQ-014 SHALL pack nonzero words into output slots 0..N-1 in increasing original index order, where N is the nonzero count (0..128).
REQ-015 SHALL, for each nonzero word, place its mt entry in the same output slot as the word.
REQ-016 SHALL compute the output slot of nonzero word i as the number of nonzero words with index below i (exclusive prefix count, 7 bits wide).
REQ-017 SHALL drive slots N..127 of both lifm_comp and mt_comp to all zeros.
REQ-018 SHALL carry the mt entry of a nonzero word unchanged, including an all-zero entry; the mt content never affects the classification.
REQ-019 SHALL drop a zero word's mt entry even when that entry is nonzero.
REQ-020 SHALL register both outputs, with a latency of exactly 1 clock: the inputs sampled at edge k appear on the outputs after edge k.
REQ-021 SHALL accept new input every cycle with no handshake and no stall; the outputs hold until the next rising edge.
REQ-022 SHALL handle the boundary cases as follows:
- N=0: all outputs zero.
- N=128: the outputs equal the inputs.
- Only word 127 nonzero: it moves to slot 0.
REQ-023 SHALL give X/Z input bits no defined behaviour; the bench drives known values only.
REQ-024 SHALL contain no other state; each output word is a pure function of the inputs from the previous cycle.

Reset
REQ-025 SHALL clear lifm_comp and mt_comp to all zeros on a rising edge where reset_n=1.
REQ-026 SHALL let reset take priority over the input when both are present on the same edge; the input of that edge is discarded.
REQ-027 SHALL, on the first edge after reset_n returns to 0, load the compressed result of the inputs present at that edge.
REQ-028 SHALL, when reset is asserted in the middle of a stream, zero the outputs on the next edge; processing then resumes normally.

Verification
REQ-029 SHALL be verified with the sparse case: words 3=13, 8=47, 15=22, their mt entries =1, all else 0 -> after 1 edge lifm_comp slots 0/1/2 = 13/47/22, mt_comp slots 0..2 = 1, all other slots 0.
REQ-030 SHALL be verified with the dense case: word i = i+1 for i=0..127 (wrapping mod 256, so word 255 would be excluded: use values 1..128) and mt i = i -> both outputs equal the inputs.
REQ-031 SHALL be verified with the empty/zero-pair case: all words 0 and mt entries all 0x5A5A5A5 -> both outputs all zero.
REQ-032 SHALL be verified with the single-tail case: only word 127 = 0xFF with mt 127 = 0x1234567 -> slot 0 = 0xFF, mt slot 0 = 0x1234567, rest 0.
REQ-033 SHALL be verified with reset priority: reset_n=1 held for one edge while the sparse-case input is applied -> outputs all 0; reset_n=0 at the next edge -> the sparse-case result appears.
REQ-034 SHALL be verified with back-to-back lines: the sparse case at edge k and the single-tail case at edge k+1 -> each result appears exactly one edge after its input, with no mixing.

Source files
------------

// File: rtl/zv_compressor128.sv
// Zero-value compressor for a 128-word line: drops all-zero words (and their map
// entries), packs survivors to the low slots in order, registers the result.

module zv_slot_sel #(
  parameter int WORD_WIDTH = 8,
  parameter int ME         = 28,
  parameter int SLOT       = 0
) (
  input  logic [127:0][WORD_WIDTH-1:0] words,
  input  logic [127:0][ME-1:0]         ents,
  input  logic [127:0]                 nz,
  input  logic [127:0][6:0]            pos,
  output logic [WORD_WIDTH-1:0]        word_o,
  output logic [ME-1:0]                ent_o
);
  localparam logic [6:0] SLOT_ID = 7'(SLOT);

  // At most one nonzero word maps to any slot; unclaimed slots stay zero.
  always_comb begin
    word_o = '0;
    ent_o  = '0;
    for (int i = 0; i < 128; i++) begin
      if (nz[i] && pos[i] == SLOT_ID) begin
        word_o = words[i];
        ent_o  = ents[i];
      end
    end
  end
endmodule

module zv_compressor128 #(
  parameter int WORD_WIDTH    = 8,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 4
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [128*WORD_WIDTH-1:0]                  lifm_line,
  input  logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]    mt_line,
  output logic [128*WORD_WIDTH-1:0]                  lifm_comp,
  output logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]    mt_comp
);
  localparam int LINE = 128;
  localparam int ME   = DIST_WIDTH * MAX_LIFM_RSIZ;

  logic [LINE-1:0][WORD_WIDTH-1:0] words, words_c;
  logic [LINE-1:0][ME-1:0]         ents, ents_c;
  logic [LINE-1:0]                 nz;
  logic [LINE-1:0][6:0]            pos;

  assign words = lifm_line;
  assign ents  = mt_line;

  // Exclusive prefix count of nonzero words gives each survivor its slot.
  always_comb begin
    logic [6:0] cnt;
    cnt = '0;
    nz  = '0;
    pos = '0;
    for (int i = 0; i < LINE; i++) begin
      nz[i]  = |words[i];
      pos[i] = cnt;
      cnt    = cnt + 7'(nz[i]);
    end
  end

  for (genvar g = 0; g < LINE; g++) begin : g_slot
    zv_slot_sel #(.WORD_WIDTH(WORD_WIDTH), .ME(ME), .SLOT(g)) u_slot (
      .words  (words),
      .ents   (ents),
      .nz     (nz),
      .pos    (pos),
      .word_o (words_c[g]),
      .ent_o  (ents_c[g])
    );
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      lifm_comp <= '0;
      mt_comp   <= '0;
    end else begin
      lifm_comp <= words_c;
      mt_comp   <= ents_c;
    end
  end
endmodule

// File: tb/tb_zv_compressor128.sv
// Directed bench for zv_compressor128 with hand-derived expected lines.

module tb_zv_compressor128;
  localparam int W  = 8;
  localparam int ME = 28;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [128*W-1:0]    lifm_line;
  logic [128*ME-1:0]   mt_line;
  logic [128*W-1:0]    lifm_comp;
  logic [128*ME-1:0]   mt_comp;

  logic [127:0][W-1:0]  exp_w;
  logic [127:0][ME-1:0] exp_m;
  int total = 0;
  int bad   = 0;

  zv_compressor128 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .lifm_line (lifm_line),
    .mt_line   (mt_line),
    .lifm_comp (lifm_comp),
    .mt_comp   (mt_comp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string name);
    for (int j = 0; j < 128; j++) begin
      chk($sformatf("%s w[%0d]", name, j), 32'(lifm_comp[j*W +: W]), 32'(exp_w[j]));
      chk($sformatf("%s m[%0d]", name, j), 32'(mt_comp[j*ME +: ME]), 32'(exp_m[j]));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    lifm_line = '0;
    mt_line   = '0;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v, input logic [ME-1:0] m);
    lifm_line[i*W +: W]   = v;
    mt_line[i*ME +: ME]   = m;
  endtask

  task automatic load_sparse;
    clr_in();
    set_word(3, 8'd13, 28'd1);
    set_word(8, 8'd47, 28'd1);
    set_word(15, 8'd22, 28'd1);
  endtask

  task automatic exp_sparse;
    exp_w = '0; exp_m = '0;
    exp_w[0] = 8'd13; exp_w[1] = 8'd47; exp_w[2] = 8'd22;
    exp_m[0] = 28'd1; exp_m[1] = 28'd1; exp_m[2] = 28'd1;
  endtask

  task automatic load_tail;
    clr_in();
    set_word(127, 8'hFF, 28'h1234567);
  endtask

  task automatic exp_tail;
    exp_w = '0; exp_m = '0;
    exp_w[0] = 8'hFF; exp_m[0] = 28'h1234567;
  endtask

  task automatic load_dense;
    clr_in();
    for (int i = 0; i < 128; i++) set_word(i, 8'(i + 1), 28'(i));
  endtask

  task automatic exp_dense;
    for (int i = 0; i < 128; i++) begin
      exp_w[i] = 8'(i + 1);
      exp_m[i] = 28'(i);
    end
  endtask

  task automatic exp_zero;
    exp_w = '0; exp_m = '0;
  endtask

  initial begin
    // Reset with a live input: outputs must be zero.
    reset_n = 1'b1;
    load_dense();
    tick();
    exp_zero(); check_out("reset");

    reset_n = 1'b0;
    load_sparse(); tick();
    exp_sparse(); check_out("sparse");

    load_dense(); tick();
    exp_dense(); check_out("dense");

    clr_in();
    for (int i = 0; i < 128; i++) mt_line[i*ME +: ME] = 28'h5A5A5A5;
    tick();
    exp_zero(); check_out("empty");

    load_tail(); tick();
    exp_tail(); check_out("tail");

    // Zero word with nonzero entry is dropped; nonzero word with zero entry is kept.
    clr_in();
    set_word(0, 8'h00, 28'hABCDEF0);
    set_word(1, 8'h80, 28'h0);
    set_word(126, 8'h01, 28'h7);
    tick();
    exp_zero();
    exp_w[0] = 8'h80; exp_m[0] = 28'h0;
    exp_w[1] = 8'h01; exp_m[1] = 28'h7;
    check_out("pair");

    // Reset priority over a present input, then resume.
    reset_n = 1'b1;
    load_sparse(); tick();
    exp_zero(); check_out("rstprio");
    reset_n = 1'b0;
    tick();
    exp_sparse(); check_out("rstrel");

    // Back-to-back lines, one edge latency each.
    load_sparse(); tick();
    exp_sparse(); check_out("b2b0");
    load_tail(); tick();
    exp_tail(); check_out("b2b1");

    // Mid-stream reset.
    load_dense(); tick();
    exp_dense(); check_out("stream");
    reset_n = 1'b1; tick();
    exp_zero(); check_out("midrst");
    reset_n = 1'b0; tick();
    exp_dense(); check_out("resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
